serial_adder: RTL and testbench

Bit-serial two-operand adder. It adds two WIDTH-bit operands LSB-first, one bit per clock, through a single one-bit full-adder cell and a registered carry. It is the addition-side counterpart of the lab's subtraction datapath and serves as the area-minimal ALU add path in later labs. A start/done handshake frames each operation, and the result is held stable until the next operation completes.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_adder.sv | 14 +
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg -- shared definitions for the bit-serial adder.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_adder_pkg;

    // FSM state encoding (plain constants so older tools can consume them)
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Width of a counter that must reach width-1: ceil(log2(width)), at least 1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder -- one-bit combinational full-adder cell used by the
// bit-serial adder's datapath.
module full_adder (
    input  logic In_A,
    input  logic In_B,
    input  logic Carry_in,
    output logic Sum,
    output logic Carry_out
);

    assign Sum       = In_A ^ In_B ^ Carry_in;
    assign Carry_out = (In_A & In_B) | (Carry_in & (In_A ^ In_B));

endmodule

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// A start/done handshake frames each operation; sum_o/carry_out_o hold the
// last committed result until the next operation completes.
// Optional feature: define SERIAL_ADDER_OVF_EN to add overflow_o, the
// two's-complement signed overflow of the completed operation.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Bits already produced; the current bit is appended on top, so only
    // WIDTH-1 bits ever need to be stored.
    logic [WIDTH-2:0] r_res;
    logic             r_carry;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res;
    logic             w_accept;
    logic             w_last;

    full_adder u_full_adder (
        .In_A      (r_a[0]),
        .In_B      (r_b[0]),
        .Carry_in  (r_carry),
        .Sum       (w_sum),
        .Carry_out (w_cout)
    );

    // Result word as it stands after the current bit step.
    assign w_res    = {w_sum, r_res};
    assign w_accept = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    assign busy_o = (r_state == ST_RUN);
    assign done_o = (r_state == ST_DONE);

    // FSM, bit counter, operand/result shift registers and running carry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: non-blocking assignments make every register here see the
        // pre-edge values of the others, which is what a shift chain needs.
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res[WIDTH-1:1];
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                // IDLE and DONE both accept; the unused encoding recovers to IDLE.
                default: begin
                    if (w_accept) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_res   <= '0;
                        r_carry <= carry_in_i;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Result registers: written only on the edge that processes the last bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sum_o       <= '0;
            carry_out_o <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow_o  <= 1'b0;
`endif
        end else if ((r_state == ST_RUN) && w_last) begin
            sum_o       <= w_res;
            carry_out_o <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // r_carry is the carry into the MSB during the final step.
            overflow_o  <= r_carry ^ w_cout;
`endif
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- self-checking bench for serial_adder (WIDTH=8).
// An arithmetic reference model tracks expected outputs every cycle;
// directed tests pin it with hand-computed literals.
// Honours SERIAL_ADDER_OVF_EN when defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             carry_in_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             carry_out_o;
`ifdef SERIAL_ADDER_OVF_EN
    logic             overflow_o;
`endif

    int n_total = 0;
    int n_pass  = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .carry_in_i  (carry_in_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sum_o       (sum_o),
        .carry_out_o (carry_out_o)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow_o  (overflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_left counts bit steps still to go; the result is computed by plain
    // addition at accept time and published when the count runs out.
    int               m_left = 0;
    logic             m_done = 1'b0;
    logic [WIDTH:0]   m_pending = '0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_pend_ovf = 1'b0;

    always @(negedge rst_i) begin
        m_left = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
    end

    always @(posedge clk_i) begin
        if (rst_i) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_sum  = m_pending[WIDTH-1:0];
                    m_cout = m_pending[WIDTH];
                    m_ovf  = m_pend_ovf;
                    m_done = 1'b1;
                end
            end else begin
                m_done = 1'b0;
                if (start_i) begin
                    m_pending  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, carry_in_i};
                    // signed overflow: like-signed operands, differently signed sum
                    m_pend_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                 (m_pending[WIDTH-1] != a_i[WIDTH-1]);
                    m_left     = WIDTH;
                end
            end
        end
    end

    // Compare every cycle while out of reset.
    always @(negedge clk_i) begin
        if (rst_i) begin
            check("busy_o", {31'd0, busy_o}, {31'd0, m_left > 0});
            check("done_o", {31'd0, done_o}, {31'd0, m_done});
            check("sum_o", {24'd0, sum_o}, {24'd0, m_sum});
            check("carry_out_o", {31'd0, carry_out_o}, {31'd0, m_cout});
`ifdef SERIAL_ADDER_OVF_EN
            check("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    // Issue one operation and wait (bounded) for done; checks latency and busy length.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int k;
        int busy_cnt;
        @(negedge clk_i);
        a_i = a; b_i = b; carry_in_i = cin; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 1;
        busy_cnt = 0;
        while (!done_o && k <= 40) begin
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
            k++;
        end
        check("done_latency", k - 1, WIDTH);
        check("busy_cycles", busy_cnt, WIDTH);
    endtask

    task automatic check_result(input string name, input logic [WIDTH-1:0] s, input logic c);
        check({name, "_sum"}, {24'd0, sum_o}, {24'd0, s});
        check({name, "_cout"}, {31'd0, carry_out_o}, {31'd0, c});
    endtask

    initial begin
        int k;
        #1;
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_sum", {24'd0, sum_o}, 32'd0);
        check("reset_cout", {31'd0, carry_out_o}, 32'd0);
        #20;
        @(negedge clk_i);
        rst_i = 1'b1;

        // Basic add
        do_op(8'h35, 8'h4A, 1'b0);
        check_result("basic", 8'h7F, 1'b0);

        // Wrap-around
        do_op(8'hFF, 8'h01, 1'b0);
        check_result("wrap", 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
        check("wrap_ovf", {31'd0, overflow_o}, 32'd0);
`endif

        // Carry-in only
        do_op(8'h00, 8'h00, 1'b1);
        check_result("cin", 8'h01, 1'b0);

        // Signed overflow
        do_op(8'h7F, 8'h01, 1'b0);
        check_result("sovf", 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("sovf_ovf", {31'd0, overflow_o}, 32'd1);
`endif

        // Ignored start in RUN, then back-to-back accept from DONE
        @(negedge clk_i);
        a_i = 8'h12; b_i = 8'h34; carry_in_i = 1'b0; start_i = 1'b1;
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk_i);
            a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); carry_in_i = 1'($urandom);
        end
        @(negedge clk_i);
        check("ign_done", {31'd0, done_o}, 32'd1);
        check_result("ign", 8'h46, 1'b0);
        a_i = 8'h56; b_i = 8'h21; carry_in_i = 1'b0;   // accepted from DONE
        @(negedge clk_i);
        start_i = 1'b0;
        check("b2b_busy", {31'd0, busy_o}, 32'd1);
        k = 1;
        while (!done_o && k <= 40) begin
            @(negedge clk_i);
            k++;
        end
        check("b2b_latency", k - 1, WIDTH);
        check_result("b2b", 8'h77, 1'b0);

        // Reset mid-RUN
        @(negedge clk_i);
        a_i = 8'h35; b_i = 8'h4A; carry_in_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_sum", {24'd0, sum_o}, 32'd0);
        check("rst_cout", {31'd0, carry_out_o}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, overflow_o}, 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_rst_idle", {30'd0, busy_o, done_o}, 32'd0);
        do_op(8'h10, 8'h20, 1'b0);
        check_result("post_rst", 8'h30, 1'b0);

        // Output hold
        do_op(8'h35, 8'h4A, 1'b0);
        repeat (20) @(negedge clk_i);
        check("hold_idle_sum", {24'd0, sum_o}, 32'h7F);
        @(negedge clk_i);
        a_i = 8'h01; b_i = 8'h01; carry_in_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 1;
        while (!done_o && k <= 40) begin
            check("hold_run_sum", {24'd0, sum_o}, 32'h7F);
            @(negedge clk_i);
            k++;
        end
        check("hold_latency", k - 1, WIDTH);
        check_result("hold_new", 8'h02, 1'b0);

        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
